ps2_key_event_queue: RTL and testbench
======================================

Name: ps2_key_event_queue

Overview:
Parametrised successor to the single-code keyboard front end. It takes raw PS/2 clock and data lines and performs the following steps:
- synchronises and filters both lines;
- frames and checks each 11-bit PS/2 frame;
- decodes E0/F0/E1 prefixes into make/break key events;
- tracks shift and caps-lock state;
- buffers events in a DEPTH-entry FIFO behind a valid/ready interface.

It feeds scancode-to-ASCII translation and any consumer that must not lose keystrokes.

Parameters:
SYNC_STAGES, 2, synchroniser flops on i_ps2_clk_n and i_ps2_dat (min 2)
FILTER_LEN, 4, consecutive equal samples required before the filtered PS/2 clock changes
TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 clock falling edge before a partial frame is aborted
DEPTH, 8, FIFO entries (power of 2, min 2)

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_ps2_clk_n  in  1  raw PS/2 clock (asynchronous)
i_ps2_dat  in  1  raw PS/2 data (asynchronous)
o_ev_valid  out  1  FIFO non-empty
i_ev_ready  in  1  consumer accepts head event
o_ev_data  out  10  {ext, brk, scancode[7:0]}
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_shift  out  1  left or right shift held
o_capslock  out  1  caps-lock toggle state
o_overflow  out  1  sticky: an event was dropped because the FIFO was full
i_ovf_clr  in  1  clears o_overflow
o_err_cnt  out  8  saturating count of framing, parity and timeout errors

Behaviour:
- Reset: asynchronous, active-low, takes effect mid-frame.
  - All outputs are 0; FIFO empty; frame FSM in IDLE; prefix flags cleared; drop counter cleared.
- Front end:
  - Both lines pass SYNC_STAGES flops.
  - The filtered clock changes only after FILTER_LEN identical synchronised samples.
  - A 1→0 transition of the filtered clock produces a one-cycle edge pulse. Call the cycle of this pulse T.
- Frame FSM, advancing on edge pulses only:
  - IDLE: a data bit of 0 moves to DATA; a 1 is ignored.
  - DATA: shift in 8 bits, LSB first.
  - PARITY: sample the parity bit.
  - STOP: sample the stop bit, then return to IDLE.
  - The frame is good if odd parity holds (data ones plus parity bit is odd) and stop = 1.
  - Good frame: byte-strobe is registered at T+1.
  - Bad frame: no strobe; o_err_cnt increments, saturating at 255.
  - Timeout: in any state other than IDLE, if TIMEOUT_CYCLES cycles pass without an edge, the FSM returns to IDLE and o_err_cnt increments. The timeout counter reloads on every edge.
- Decoder, acting on the byte strobe:
  - E0: sets ext.
  - F0: sets brk.
  - E1: loads the drop counter with 7; the next 7 bytes are discarded and no event is emitted.
  - 00, FF, AA, FA: discarded; ext and brk are cleared.
  - Any other byte: pushes {ext, brk, byte} at T+2, then clears ext and brk.
  - Modifiers (non-ext only):
    - 12 and 59 set/clear their held bit on make/break; o_shift is the OR of both.
    - 58 make toggles o_capslock only when caps is not already held, so typematic repeats do not toggle.
    - 58 break clears caps-held.
  - Modifier events are still pushed to the FIFO.
- FIFO:
  - Registered occupancy. o_ev_valid rises at T+3 when the FIFO was empty.
  - Transfer occurs when o_ev_valid and i_ev_ready are both high.
  - o_ev_data is the head entry; it must stay stable while valid and not ready.
  - Push when full without a simultaneous pop: the event is dropped and o_overflow is set.
  - Push and pop in the same cycle while full: both succeed and o_count is unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
  - o_overflow clears on i_ovf_clr unless a drop happens in the same cycle; the drop wins.

Decomposition:
- Package kb_pkg holds:
  - prefix constants: E0, F0, E1;
  - discard codes: 00, FF, AA, FA;
  - modifier codes: 12, 59, 58;
  - the event field positions.
- Sub-module sync_fifo (DEPTH and WIDTH parametrised) holds storage, pointers and count.
- Framing and decoding live in the top module.

Test Plan:
- Frame 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1), i_ev_ready=1 → o_ev_valid pulses with o_ev_data=10'h01C, latency T+3 from the stop edge.
- Bytes E0,F0,75 → a single event 10'h375; ext and brk are cleared afterwards.
- Make 12, 58 make sent 3 times, 58 break, break 12 → o_shift goes 1 then 0; o_capslock=1 after the first 58 only; 6 events queued.
- i_ev_ready=0, send DEPTH+1 make codes 0x1C → o_count=DEPTH, o_overflow=1; the first DEPTH codes read back in order. Repeat with full FIFO and simultaneous pop and push → o_count stays DEPTH and o_overflow does not newly set.
- Frame 0x1C with parity 1 → no event, o_err_cnt=1. Stop clock after 5 bits → after TIMEOUT_CYCLES, o_err_cnt=2 and the next good frame decodes.
- Assert i_rst_n=0 mid-frame with the FIFO holding 3 events → all outputs immediately 0; the next full frame decodes correctly.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared PS/2 keyboard codes, event layout and frame states.
// Event word layout: {ext, brk, scancode[7:0]}.
package kb_pkg;

    localparam logic [7:0] KB_E0     = 8'hE0;
    localparam logic [7:0] KB_F0     = 8'hF0;
    localparam logic [7:0] KB_E1     = 8'hE1;

    localparam logic [7:0] KB_NUL    = 8'h00;
    localparam logic [7:0] KB_ERR    = 8'hFF;
    localparam logic [7:0] KB_BAT    = 8'hAA;
    localparam logic [7:0] KB_ACK    = 8'hFA;

    localparam logic [7:0] KB_LSHIFT = 8'h12;
    localparam logic [7:0] KB_RSHIFT = 8'h59;
    localparam logic [7:0] KB_CAPS   = 8'h58;

    localparam int EV_CODE_W = 8;
    localparam int EV_BRK    = 8;
    localparam int EV_EXT    = 9;
    localparam int EV_W      = 10;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    function automatic logic is_discard(input logic [7:0] code);
        return (code == KB_NUL) || (code == KB_ERR) || (code == KB_BAT) || (code == KB_ACK);
    endfunction

    function automatic logic [EV_W-1:0] ev_pack(input logic ext, input logic brk,
                                                input logic [EV_CODE_W-1:0] code);
        logic [EV_W-1:0] ev;
        ev                   = '0;
        ev[EV_EXT]           = ext;
        ev[EV_BRK]           = brk;
        ev[EV_CODE_W-1:0]    = code;
        return ev;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered occupancy and first-word fall-through head.
// Latency: a write is visible on o_rd_vld/o_rd_dat the cycle after it is accepted.
// Backpressure: writes when full are refused unless a read happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_vld,
    input  logic [WIDTH-1:0]         i_wr_dat,
    output logic                     o_full,
    input  logic                     i_rd_rdy,
    output logic                     o_rd_vld,
    output logic [WIDTH-1:0]         o_rd_dat,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign o_full   = (o_count == (AW+1)'(DEPTH));
    assign o_rd_vld = (o_count != '0);
    assign o_rd_dat = mem[rd_ptr];
    assign rd_en    = i_rd_rdy && o_rd_vld;
    assign wr_en    = i_wr_vld && (!o_full || rd_en);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= i_wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 keyboard front end: sync/filter, frame check, prefix decode, modifier tracking, event FIFO.
// Latency: event valid 3 cycles after the filtered stop-bit falling edge pulse (T+3).
// Backpressure: valid/ready on the FIFO head; events arriving while full are dropped and flagged.
module ps2_key_event_queue
    import kb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DEPTH          = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_ps2_clk_n,
    input  logic                     i_ps2_dat,
    output logic                     o_ev_valid,
    input  logic                     i_ev_ready,
    output logic [EV_W-1:0]          o_ev_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_shift,
    output logic                     o_capslock,
    output logic                     o_overflow,
    input  logic                     i_ovf_clr,
    output logic [7:0]               o_err_cnt
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   clk_filt;
    logic [FW-1:0]          flt_cnt;
    logic                   fall;
    logic                   edge_q;

    logic [TW-1:0]          tmo_cnt;
    frame_state_t           state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_q;
    logic                   byte_stb;
    logic [7:0]             byte_q;

    logic                   ext;
    logic                   brk;
    logic [2:0]             drop_cnt;
    logic                   lshift;
    logic                   rshift;
    logic                   caps_held;
    logic                   push_vld;
    logic [EV_W-1:0]        push_dat;
    logic                   fifo_full;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign fall    = clk_filt && !clk_s && (flt_cnt == FW'(FILTER_LEN - 1));
    assign o_shift = lshift || rshift;

    // Idle PS/2 lines are high, so the front end resets to that level.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_filt   <= 1'b1;
            flt_cnt    <= '0;
            edge_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk_n};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_ps2_dat};
            edge_q     <= fall;
            if (clk_s == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= FR_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_q     <= 1'b0;
            byte_stb  <= 1'b0;
            byte_q    <= '0;
            tmo_cnt   <= '0;
            o_err_cnt <= '0;
        end else begin
            byte_stb <= 1'b0;
            if (state == FR_IDLE || edge_q) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_cnt <= '0;
                state   <= FR_IDLE;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (edge_q) begin
                case (state)
                    FR_IDLE: begin
                        if (!dat_s) begin
                            state   <= FR_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    FR_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= FR_PARITY;
                    end
                    FR_PARITY: begin
                        par_q <= dat_s;
                        state <= FR_STOP;
                    end
                    FR_STOP: begin
                        state <= FR_IDLE;
                        if (dat_s && (^shreg ^ par_q)) begin
                            byte_stb <= 1'b1;
                            byte_q   <= shreg;
                        end else if (o_err_cnt != 8'hFF) begin
                            o_err_cnt <= o_err_cnt + 8'd1;
                        end
                    end
                    default: state <= FR_IDLE;
                endcase
            end
        end
    end

    // Bytes swallowed by the E1 drop window leave ext/brk untouched.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            drop_cnt   <= '0;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            caps_held  <= 1'b0;
            o_capslock <= 1'b0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
        end else begin
            push_vld <= 1'b0;
            if (byte_stb) begin
                if (drop_cnt != 3'd0) begin
                    drop_cnt <= drop_cnt - 3'd1;
                end else if (byte_q == KB_E1) begin
                    drop_cnt <= 3'd7;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end else if (byte_q == KB_E0) begin
                    ext <= 1'b1;
                end else if (byte_q == KB_F0) begin
                    brk <= 1'b1;
                end else if (is_discard(byte_q)) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    push_vld <= 1'b1;
                    push_dat <= ev_pack(ext, brk, byte_q);
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                    if (!ext) begin
                        if (byte_q == KB_LSHIFT) lshift <= !brk;
                        if (byte_q == KB_RSHIFT) rshift <= !brk;
                        if (byte_q == KB_CAPS) begin
                            if (brk) begin
                                caps_held <= 1'b0;
                            end else if (!caps_held) begin
                                caps_held  <= 1'b1;
                                o_capslock <= !o_capslock;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (push_vld && fifo_full && !i_ev_ready) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_wr_vld (push_vld),
        .i_wr_dat (push_dat),
        .o_full   (fifo_full),
        .i_rd_rdy (i_ev_ready),
        .o_rd_vld (o_ev_valid),
        .o_rd_dat (o_ev_data),
        .o_count  (o_count)
    );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed + randomized bench for ps2_key_event_queue against a keystroke-level reference model.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2c;
    logic       ps2d;
    logic       rdy;
    logic       clr;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic [3:0] count;
    logic       shift;
    logic       caps;
    logic       ovf;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    bit m_ext, m_brk, m_l, m_r, m_caps, m_held, m_ovf;
    int m_drop, m_err;

    ps2_key_event_queue #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO),
        .DEPTH          (DEPTH)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk_n (ps2c),
        .i_ps2_dat   (ps2d),
        .o_ev_valid  (ev_valid),
        .i_ev_ready  (rdy),
        .o_ev_data   (ev_data),
        .o_count     (count),
        .o_shift     (shift),
        .o_capslock  (caps),
        .o_overflow  (ovf),
        .i_ovf_clr   (clr),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_l = 0; m_r = 0; m_caps = 0; m_held = 0; m_ovf = 0;
        m_drop = 0; m_err = 0;
    endtask

    // Keystroke semantics of one received byte.
    task automatic model_byte(input logic [7:0] b);
        if (m_drop > 0) begin
            m_drop--;
        end else if (b == 8'hE1) begin
            m_drop = 7; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA) begin
            m_ext = 0; m_brk = 0;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
            else m_ovf = 1;
            if (!m_ext) begin
                if (b == 8'h12) m_l = !m_brk;
                if (b == 8'h59) m_r = !m_brk;
                if (b == 8'h58) begin
                    if (m_brk) m_held = 0;
                    else if (!m_held) begin
                        m_caps = !m_caps;
                        m_held = 1;
                    end
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        tick(4);
        ps2c = 1'b0;
        tick(8);
        ps2c = 1'b1;
        tick(4);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit par_flip);
        return {1'b1, (~^b) ^ par_flip, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit par_flip);
        logic [10:0] fr;
        fr = frame_of(b, par_flip);
        for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
        tick(2);
        if (par_flip) m_err++;
        else model_byte(b);
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hE0 || b == 8'hF0 || b == 8'hE1 || b == 8'h00 ||
               b == 8'hFF || b == 8'hAA || b == 8'hFA);
        return b;
    endfunction

    task automatic pop_check(input string tag);
        int w;
        logic [9:0] e;
        w = 0;
        while (!ev_valid && w < 200) begin
            tick(1);
            w++;
        end
        chk({tag, "_vld"}, 32'(ev_valid), 32'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        chk({tag, "_dat"}, 32'(ev_data), 32'(e));
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        chk({tag, "_empty"}, 32'(count), 32'(0));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_shift"}, 32'(shift), 32'(m_l | m_r));
        chk({tag, "_caps"}, 32'(caps), 32'(m_caps));
        chk({tag, "_cnt"}, 32'(count), 32'(exp_q.size()));
        chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
    endtask

    initial begin
        logic [10:0] fr;
        logic [9:0]  head;
        rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rdy = 1'b0; clr = 1'b0;
        model_reset();
        tick(3);
        chk("rst_valid", 32'(ev_valid), 32'(0));
        chk("rst_data", 32'(ev_data), 32'(0));
        check_state("rst");
        rst_n = 1'b1;
        tick(5);

        // Stop-bit edge to valid: sync + filter + frame/decode/FIFO stages.
        fr = frame_of(8'h1C, 0);
        for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
        ps2d = 1'b1;
        tick(4);
        ps2c = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            if (i == 8) chk("lat_early", 32'(ev_valid), 32'(0));
            if (i == 9) begin
                chk("lat_valid", 32'(ev_valid), 32'(1));
                chk("lat_data", 32'(ev_data), 32'h01C);
            end
        end
        ps2c = 1'b1;
        tick(4);
        model_byte(8'h1C);
        drain("first");

        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        chk("ext_brk_cnt", 32'(count), 32'(1));
        chk("ext_brk_dat", 32'(ev_data), 32'h375);
        send_frame(8'h1C, 0);
        drain("ext_brk");

        send_frame(8'h12, 0);
        chk("shift_make", 32'(shift), 32'(1));
        send_frame(8'h58, 0);
        chk("caps_first", 32'(caps), 32'(1));
        send_frame(8'h58, 0); send_frame(8'h58, 0);
        chk("caps_repeat", 32'(caps), 32'(1));
        send_frame(8'hF0, 0); send_frame(8'h58, 0);
        send_frame(8'hF0, 0); send_frame(8'h12, 0);
        chk("shift_break", 32'(shift), 32'(0));
        chk("mod_count", 32'(count), 32'(6));
        check_state("mod");
        drain("mod");

        send_frame(8'hE1, 0);
        for (int i = 0; i < 7; i++) send_frame(8'($urandom_range(0, 255)), 0);
        send_frame(8'h1C, 0);
        chk("e1_count", 32'(count), 32'(1));
        drain("e1");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                int sel;
                sel = $urandom_range(0, 9);
                send_frame(sel == 0 ? 8'hE0 : sel == 1 ? 8'hF0 : rand_code(), 0);
            end
            send_frame(8'hAA, 0);
            check_state("rnd");
            drain("rnd");
        end

        for (int i = 0; i < DEPTH + 1; i++) send_frame(rand_code(), 0);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_flag", 32'(ovf), 32'(1));
        drain("ovf");
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_ovf = 0;
        chk("ovf_clr", 32'(ovf), 32'(0));

        // Refill, then pop exactly in the cycle the next event is pushed.
        for (int i = 0; i < DEPTH; i++) send_frame(rand_code(), 0);
        chk("full_count", 32'(count), 32'(DEPTH));
        fr = frame_of(8'h2A, 0);
        for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
        ps2d = 1'b1;
        tick(4);
        ps2c = 1'b0;
        tick(8);
        head = exp_q.pop_front();
        chk("pp_head", 32'(ev_data), 32'(head));
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        model_byte(8'h2A);
        ps2c = 1'b1;
        tick(4);
        chk("pp_count", 32'(count), 32'(DEPTH));
        chk("pp_ovf", 32'(ovf), 32'(0));
        drain("pp");

        send_frame(8'h1C, 1);
        chk("par_err", 32'(err_cnt), 32'(1));
        chk("par_noev", 32'(ev_valid), 32'(0));

        fr = frame_of(8'h1C, 0);
        for (int i = 0; i < 5; i++) ps2_bit(fr[i]);
        tick(TMO - 60);
        chk("tmo_before", 32'(err_cnt), 32'(1));
        tick(100);
        m_err++;
        chk("tmo_after", 32'(err_cnt), 32'(2));
        send_frame(8'h1C, 0);
        check_state("tmo");
        drain("tmo");

        send_frame(8'h12, 0); send_frame(8'h1C, 0); send_frame(8'h2A, 0);
        chk("pre_rst_cnt", 32'(count), 32'(3));
        fr = frame_of(8'h33, 0);
        for (int i = 0; i < 3; i++) ps2_bit(fr[i]);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(ev_valid), 32'(0));
        chk("mid_rst_data", 32'(ev_data), 32'(0));
        check_state("mid_rst");
        tick(3);
        rst_n = 1'b1;
        tick(5);
        send_frame(8'h1C, 0);
        check_state("post_rst");
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
